// File: rtl/seq_bcd_seg_driver.sv
// Sequential binary-to-display driver for the board 7-segment bank.
// A value is accepted over valid/ready. In decimal mode it is converted to BCD with
// shift-add-3, one input bit per clock. In hex mode it is shown nibble by nibble.
// Registered BCD, active-low segments and overflow hold until the next result.
module seq_bcd_seg_driver #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_hex,
   input  logic                  in_blank_lz,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int SW = 7 * DIGITS;
   localparam int PW = (WIDTH > BW) ? WIDTH : BW;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_DARK = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      HEX
   } state_t;

   state_t            state_q, state_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [SW-1:0]     seg_q, seg_d;
   logic              ovf_q, ovf_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     scratch_q, scratch_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              blank_q, blank_d;
   logic              acc_ovf_q, acc_ovf_d;

   logic [BW-1:0]     adj;
   logic              shift_out;
   logic [BW-1:0]     scratch_shift;
   logic [PW-1:0]     padded;
   logic              hex_ovf;

   // Active-low segment pattern of one nibble; letters only exist in hex mode
   function automatic logic [6:0] seg_lut(input logic [3:0] n, input logic hx);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = hx ? 7'b0001000 : SEG_DARK;
         4'hB: s = hx ? 7'b0000011 : SEG_DARK;
         4'hC: s = hx ? 7'b1000110 : SEG_DARK;
         4'hD: s = hx ? 7'b0100001 : SEG_DARK;
         4'hE: s = hx ? 7'b0000110 : SEG_DARK;
         default: s = hx ? 7'b0001110 : SEG_DARK;
      endcase
      return s;
   endfunction

   // Full segment bank: dashes on overflow, otherwise digits with optional
   // blanking of zeros above the most significant nonzero digit (digit 0 always lit)
   function automatic logic [SW-1:0] build_seg(input logic [BW-1:0] b, input logic hx,
                                               input logic bl, input logic ov);
      logic [SW-1:0] s;
      logic          lead;
      logic [3:0]    nib;
      s    = '1;
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         nib = b[4*k +: 4];
         if (nib != 4'd0) lead = 1'b0;
         if (ov) s[7*k +: 7] = SEG_DASH;
         else if (bl && lead && (k != 0)) s[7*k +: 7] = SEG_DARK;
         else s[7*k +: 7] = seg_lut(nib, hx);
      end
      return s;
   endfunction

   // One shift-add-3 step of the scratch digits plus the hex view of the captured value
   always_comb begin
      adj = scratch_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
      shift_out     = adj[BW-1];
      scratch_shift = {adj[BW-2:0], data_q[WIDTH-1]};
      padded        = PW'(data_q);
      hex_ovf       = |(padded >> BW);
   end

   // Next-state and next-output logic for the IDLE/CONV/HEX controller
   always_comb begin
      state_d   = state_q;
      ready_d   = ready_q;
      valid_d   = 1'b0;
      bcd_d     = bcd_q;
      seg_d     = seg_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      scratch_d = scratch_q;
      data_d    = data_q;
      blank_d   = blank_q;
      acc_ovf_d = acc_ovf_q;
      case (state_q)
         IDLE: begin
            if (!ready_q) begin
               ready_d = 1'b1;
            end else if (in_valid) begin
               ready_d   = 1'b0;
               data_d    = in_data;
               blank_d   = in_blank_lz;
               scratch_d = '0;
               cnt_d     = '0;
               acc_ovf_d = 1'b0;
               state_d   = in_hex ? HEX : CONV;
            end
         end
         CONV: begin
            scratch_d = scratch_shift;
            data_d    = data_q << 1;
            acc_ovf_d = acc_ovf_q | shift_out;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = IDLE;
               valid_d = 1'b1;
               bcd_d   = scratch_shift;
               ovf_d   = acc_ovf_q | shift_out;
               seg_d   = build_seg(scratch_shift, 1'b0, blank_q, acc_ovf_q | shift_out);
            end
         end
         HEX: begin
            state_d = IDLE;
            valid_d = 1'b1;
            bcd_d   = padded[BW-1:0];
            ovf_d   = hex_ovf;
            seg_d   = build_seg(padded[BW-1:0], 1'b1, blank_q, hex_ovf);
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset aborts any conversion and darkens the display
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         bcd_q     <= '0;
         seg_q     <= '1;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         scratch_q <= '0;
         data_q    <= '0;
         blank_q   <= 1'b0;
         acc_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         bcd_q     <= bcd_d;
         seg_q     <= seg_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         scratch_q <= scratch_d;
         data_q    <= data_d;
         blank_q   <= blank_d;
         acc_ovf_q <= acc_ovf_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign bcd       = bcd_q;
   assign seg       = seg_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_bcd_seg_driver.sv
// Bench for seq_bcd_seg_driver: a 3-digit and a 2-digit instance (both 8-bit input)
// share one data bus; results are compared against an arithmetic display model.
module tb_seq_bcd_seg_driver;

   logic        clk;
   logic        rstN;
   logic [7:0]  inData;
   logic        inHex;
   logic        inBlank;

   logic        validA, readyA, outValidA, ovfA;
   logic [11:0] bcdA;
   logic [20:0] segA;

   logic        validB, readyB, outValidB, ovfB;
   logic [7:0]  bcdB;
   logic [13:0] segB;

   int          sel;
   logic        selReady, selOutValid, selOvf;
   logic [11:0] selBcd;
   logic [20:0] selSeg;

   int          compared;
   int          mismatched;

   logic [6:0]  segTable [16];

   seq_bcd_seg_driver #(.WIDTH(8), .DIGITS(3)) dutA (
      .clk(clk), .rst_n(rstN), .in_valid(validA), .in_ready(readyA),
      .in_data(inData), .in_hex(inHex), .in_blank_lz(inBlank),
      .out_valid(outValidA), .bcd(bcdA), .seg(segA), .overflow(ovfA)
   );

   seq_bcd_seg_driver #(.WIDTH(8), .DIGITS(2)) dutB (
      .clk(clk), .rst_n(rstN), .in_valid(validB), .in_ready(readyB),
      .in_data(inData), .in_hex(inHex), .in_blank_lz(inBlank),
      .out_valid(outValidB), .bcd(bcdB), .seg(segB), .overflow(ovfB)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Route the currently selected instance onto common observation signals
   always_comb begin
      if (sel == 0) begin
         selReady    = readyA;
         selOutValid = outValidA;
         selOvf      = ovfA;
         selBcd      = bcdA;
         selSeg      = segA;
      end else begin
         selReady    = readyB;
         selOutValid = outValidB;
         selOvf      = ovfB;
         selBcd      = 12'(bcdB);
         selSeg      = 21'(segB);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Display model: digits by division, overflow by magnitude, blanking by leading-digit search
   function automatic void modelResult(input int value, input bit hexMode, input bit blankMode,
                                       input int nDigits, output logic [11:0] expBcd,
                                       output logic [20:0] expSeg, output logic expOvf);
      int base;
      int limit;
      int msd;
      int digit [3];
      base  = hexMode ? 16 : 10;
      limit = 1;
      for (int k = 0; k < nDigits; k++) limit = limit * base;
      expOvf = (value >= limit);
      msd    = 0;
      expBcd = '0;
      expSeg = '0;
      for (int k = 0; k < nDigits; k++) begin
         int p;
         p = 1;
         for (int j = 0; j < k; j++) p = p * base;
         digit[k] = (value / p) % base;
         if (digit[k] != 0) msd = k;
         expBcd[4*k +: 4] = 4'(digit[k]);
      end
      for (int k = 0; k < nDigits; k++) begin
         if (expOvf) expSeg[7*k +: 7] = 7'b0111111;
         else if (blankMode && k > msd) expSeg[7*k +: 7] = 7'b1111111;
         else expSeg[7*k +: 7] = segTable[digit[k]];
      end
   endfunction

   // One full transaction on the selected instance, checking handshake, latency and result
   task automatic applyStimulus(input int which, input int value, input bit hexMode, input bit blankMode);
      logic [11:0] expBcd;
      logic [20:0] expSeg;
      logic        expOvf;
      int          lat;
      int          waits;
      sel = which;
      modelResult(value, hexMode, blankMode, (which == 0) ? 3 : 2, expBcd, expSeg, expOvf);
      @(negedge clk);
      waits = 0;
      while (!selReady && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      checkOutput("ready_before_accept", 32'(selReady), 32'd1);
      inData  = 8'(value);
      inHex   = hexMode;
      inBlank = blankMode;
      if (which == 0) validA = 1'b1;
      else validB = 1'b1;
      @(negedge clk);
      validA = 1'b0;
      validB = 1'b0;
      inData = 8'($urandom_range(0, 255));
      checkOutput("ready_low_busy", 32'(selReady), 32'd0);
      lat = 0;
      while (!selOutValid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("out_valid_seen", 32'(selOutValid), 32'd1);
      checkOutput("latency", 32'(lat), hexMode ? 32'd1 : 32'd8);
      checkOutput("bcd", 32'(selBcd), 32'(expBcd));
      checkOutput("seg", 32'(selSeg), 32'(expSeg));
      checkOutput("overflow", 32'(selOvf), 32'(expOvf));
      checkOutput("ready_in_valid_cycle", 32'(selReady), 32'd0);
      @(negedge clk);
      checkOutput("valid_pulse_len", 32'(selOutValid), 32'd0);
      checkOutput("ready_after", 32'(selReady), 32'd1);
      checkOutput("bcd_hold", 32'(selBcd), 32'(expBcd));
      checkOutput("seg_hold", 32'(selSeg), 32'(expSeg));
   endtask

   // Directed scenarios, reset abort, back-to-back handshake and randomized traffic
   initial begin
      logic [11:0] expBcd;
      logic [20:0] expSeg;
      logic        expOvf;
      logic [11:0] seenBcd [$];
      int          vals [3];
      int          idx;
      bit          pendingAccept;
      bit          sawValid;

      segTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      compared   = 0;
      mismatched = 0;
      sel        = 0;
      rstN       = 1'b0;
      validA     = 1'b0;
      validB     = 1'b0;
      inData     = '0;
      inHex      = 1'b0;
      inBlank    = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_ready_a", 32'(readyA), 32'd1);
      checkOutput("rst_valid_a", 32'(outValidA), 32'd0);
      checkOutput("rst_bcd_a", 32'(bcdA), 32'd0);
      checkOutput("rst_seg_a", 32'(segA), 32'h1FFFFF);
      checkOutput("rst_ovf_a", 32'(ovfA), 32'd0);
      checkOutput("rst_seg_b", 32'(segB), 32'h3FFF);
      rstN = 1'b1;

      applyStimulus(0, 255, 1'b0, 1'b0);
      applyStimulus(0, 0, 1'b0, 1'b1);
      applyStimulus(0, 8'hAF, 1'b1, 1'b1);
      applyStimulus(0, 7, 1'b0, 1'b1);
      applyStimulus(0, 8'h05, 1'b1, 1'b0);
      applyStimulus(1, 99, 1'b0, 1'b0);
      applyStimulus(1, 100, 1'b0, 1'b1);
      applyStimulus(1, 8'hFF, 1'b1, 1'b0);
      applyStimulus(0, 200, 1'b0, 1'b0);

      // Reset part way through a decimal conversion
      sel = 0;
      @(negedge clk);
      inData  = 8'd123;
      inHex   = 1'b0;
      inBlank = 1'b0;
      validA  = 1'b1;
      @(negedge clk);
      validA = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("abort_bcd", 32'(bcdA), 32'd0);
      checkOutput("abort_seg", 32'(segA), 32'h1FFFFF);
      checkOutput("abort_ovf", 32'(ovfA), 32'd0);
      checkOutput("abort_ready", 32'(readyA), 32'd1);
      sawValid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         sawValid |= outValidA;
      end
      rstN = 1'b1;
      repeat (10) begin
         @(negedge clk);
         sawValid |= outValidA;
      end
      checkOutput("abort_no_valid", 32'(sawValid), 32'd0);
      checkOutput("abort_ready_after", 32'(readyA), 32'd1);
      applyStimulus(0, 37, 1'b0, 1'b0);

      // Back-to-back values with in_valid held high throughout
      vals = '{12, 200, 7};
      sel  = 0;
      @(negedge clk);
      idx           = 0;
      pendingAccept = 1'b0;
      inHex         = 1'b0;
      inBlank       = 1'b0;
      inData        = 8'(vals[0]);
      validA        = 1'b1;
      for (int c = 0; c < 80; c++) begin
         if (c > 0) @(negedge clk);
         if (outValidA) seenBcd.push_back(bcdA);
         if (pendingAccept) begin
            idx++;
            if (idx < 3) inData = 8'(vals[idx]);
            else validA = 1'b0;
         end
         pendingAccept = validA && readyA;
      end
      validA = 1'b0;
      checkOutput("b2b_count", 32'(seenBcd.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         modelResult(vals[i], 1'b0, 1'b0, 3, expBcd, expSeg, expOvf);
         if (i < seenBcd.size()) checkOutput("b2b_bcd", 32'(seenBcd[i]), 32'(expBcd));
      end

      // Randomized traffic on both instances
      for (int i = 0; i < 25; i++) begin
         applyStimulus(0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
